// File: rtl/fft_cp_strip_feeder.sv
// fft_cp_strip_feeder: strips the cyclic prefix and feeds N-sample symbols to a radix-2 FFT.
// Two-bank ping-pong buffer; each full bank is emitted as N/2 (x[k], x[k+N/2]) pairs.
package fft_cp_strip_feeder_pkg;
    typedef struct packed {
        logic signed [31:0] re;
        logic signed [31:0] im;
    } complex_product_t;
endpackage

module fft_cp_strip_feeder
    import fft_cp_strip_feeder_pkg::*;
#(
    parameter int N      = 8,
    parameter int CP_LEN = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  complex_product_t in_data,
    input  logic             sym_start,
    output complex_product_t data_0,
    output complex_product_t data_1,
    output logic             out_enable,
    output logic             sym_abort
);
    localparam int LG = $clog2(N);
    localparam logic [LG-1:0] CP_LAST = LG'(CP_LEN == 0 ? 0 : CP_LEN - 1);

    typedef enum logic [1:0] {IDLE, STRIP, FILL} state_t;

    state_t           r_state;
    logic [LG-1:0]    r_cnt;
    logic             r_wbank;
    logic             r_rbank;
    logic [1:0]       r_full;
    logic [LG-2:0]    r_rd_cnt;
    complex_product_t r_mem [2*N];

    logic          w_start;
    logic          w_fill;
    logic          w_we;
    logic [LG:0]   w_waddr;
    logic          w_last;
    logic          w_nbank;
    logic          w_go;
    logic [LG-2:0] w_rd_k;

    assign w_start = in_valid && sym_start;
    assign w_fill  = in_valid && !sym_start && r_state == FILL;
    // with no prefix the sym_start sample itself is x[0]
    assign w_we    = !reset && (w_fill || (w_start && CP_LEN == 0));
    assign w_waddr = {r_wbank, w_start ? LG'(0) : r_cnt};
    assign w_last  = out_enable && (&r_rd_cnt);
    assign w_nbank = w_last ? !r_rbank : r_rbank;
    assign w_go    = (!out_enable || w_last) && r_full[w_nbank];
    assign w_rd_k  = w_go ? '0 : r_rd_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_wbank    <= 1'b0;
            r_rbank    <= 1'b0;
            r_full     <= '0;
            r_rd_cnt   <= '0;
            out_enable <= 1'b0;
            sym_abort  <= 1'b0;
            data_0     <= '0;
            data_1     <= '0;
        end else begin
            sym_abort <= w_start && r_state != IDLE;
            if (w_start) begin
                r_state <= CP_LEN <= 1 ? FILL : STRIP;
                r_cnt   <= CP_LEN == 1 ? LG'(0) : LG'(1);
            end else if (in_valid && r_state == STRIP) begin
                r_state <= r_cnt == CP_LAST ? FILL : STRIP;
                r_cnt   <= r_cnt == CP_LAST ? '0 : r_cnt + 1'b1;
            end else if (w_fill) begin
                r_state <= &r_cnt ? IDLE : FILL;
                r_cnt   <= r_cnt + 1'b1;
                if (&r_cnt) r_wbank <= !r_wbank;
            end
            if (w_go) r_full[w_nbank] <= 1'b0;
            if (w_fill && &r_cnt) r_full[r_wbank] <= 1'b1;
            // a burst never drops early; a waiting full bank chains straight on
            if (w_go || (out_enable && !w_last)) begin
                data_0   <= r_mem[{w_nbank, 1'b0, w_rd_k}];
                data_1   <= r_mem[{w_nbank, 1'b1, w_rd_k}];
                r_rd_cnt <= w_rd_k;
            end
            out_enable <= w_go || (out_enable && !w_last);
            r_rbank    <= w_nbank;
        end
    end
endmodule

// File: tb/tb_fft_cp_strip_feeder.sv
// tb_fft_cp_strip_feeder: scoreboard bench; stimulus pushes expected FFT pairs, monitors pop and compare.
module tb_fft_cp_strip_feeder;
    import fft_cp_strip_feeder_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic reset0 = 1'b1;
    logic in_valid = 1'b0;
    logic sym_start = 1'b0;
    complex_product_t in_data = '0;
    complex_product_t data_0, data_1, b_data_0, b_data_1;
    logic out_enable, sym_abort, b_out_enable, b_sym_abort;

    int n_chk = 0;
    int n_fail = 0;
    int n_abort = 0;
    int run_a = 0;
    int run_b = 0;
    int qa0[$], qa1[$], q_len[$], qb0[$], qb1[$];

    always #5 clk = !clk;

    fft_cp_strip_feeder #(.N(8), .CP_LEN(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .sym_start(sym_start),
        .data_0(data_0), .data_1(data_1), .out_enable(out_enable), .sym_abort(sym_abort)
    );

    fft_cp_strip_feeder #(.N(8), .CP_LEN(0)) dut0 (
        .clk(clk), .reset(reset0), .in_valid(in_valid), .in_data(in_data), .sym_start(sym_start),
        .data_0(b_data_0), .data_1(b_data_1), .out_enable(b_out_enable), .sym_abort(b_sym_abort)
    );

    function automatic complex_product_t mk(int v);
        complex_product_t r;
        r.re = v;
        r.im = -v;
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(int v, bit ss);
        in_valid = 1'b1;
        sym_start = ss;
        in_data = mk(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sym_start = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_sym(int base, int pairs);
        for (int k = 0; k < pairs; k++) begin
            qa0.push_back(base + 2 + k);
            qa1.push_back(base + 6 + k);
        end
        q_len.push_back(pairs);
    endtask

    task automatic send_sym(int base);
        for (int i = 0; i < 10; i++) send(base + i, i == 0);
    endtask

    always @(negedge clk) begin
        if (sym_abort) n_abort++;
        if (out_enable) begin
            run_a++;
            if (qa0.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out: got data_0 %h with empty scoreboard", data_0);
            end else begin
                check("data_0", data_0, mk(qa0.pop_front()));
                check("data_1", data_1, mk(qa1.pop_front()));
            end
        end else if (run_a != 0) begin
            check("burst_len", 64'(run_a), 64'(q_len.size() != 0 ? q_len.pop_front() : 0));
            run_a = 0;
        end
    end

    always @(negedge clk) begin
        if (b_out_enable) begin
            run_b++;
            if (qb0.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out_cp0: got data_0 %h with empty scoreboard", b_data_0);
            end else begin
                check("cp0_data_0", b_data_0, mk(qb0.pop_front()));
                check("cp0_data_1", b_data_1, mk(qb1.pop_front()));
            end
        end else if (run_b != 0) begin
            check("cp0_burst_len", 64'(run_b), 64'(4));
            run_b = 0;
        end
    end

    initial begin
        idle(3);
        reset = 1'b0;
        check("rst_oe", 64'(out_enable), 64'(0));
        check("rst_abort", 64'(sym_abort), 64'(0));
        check("rst_d0", data_0, 64'(0));
        check("rst_d1", data_1, 64'(0));
        check("rst_oe_cp0", 64'(b_out_enable), 64'(0));

        // contiguous symbol with latency probe
        push_sym(100, 4);
        send_sym(100);
        @(negedge clk);
        check("lat_oe_low", 64'(out_enable), 64'(0));
        @(negedge clk);
        check("lat_oe_high", 64'(out_enable), 64'(1));
        idle(10);

        // same symbol with gaps on every other cycle
        push_sym(200, 4);
        for (int i = 0; i < 10; i++) begin
            send(200 + i, i == 0);
            idle(1);
        end
        idle(10);

        // three back-to-back symbols
        push_sym(300, 4);
        push_sym(400, 4);
        push_sym(500, 4);
        send_sym(300);
        send_sym(400);
        send_sym(500);
        idle(10);

        // resync at fill index 5
        for (int i = 0; i < 7; i++) send(600 + i, i == 0);
        push_sym(700, 4);
        send(700, 1'b1);
        check("abort_pulse", 64'(sym_abort), 64'(1));
        for (int i = 1; i < 10; i++) send(700 + i, 1'b0);
        idle(10);

        // reset during burst cycle 2
        push_sym(800, 3);
        send_sym(800);
        idle(3);
        reset = 1'b1;
        idle(1);
        check("rst_mid_oe", 64'(out_enable), 64'(0));
        check("rst_mid_d0", data_0, 64'(0));
        reset = 1'b0;
        push_sym(900, 4);
        send_sym(900);
        idle(10);

        // zero-length prefix on the second instance
        reset = 1'b1;
        reset0 = 1'b0;
        idle(1);
        for (int k = 0; k < 4; k++) begin
            qb0.push_back(k);
            qb1.push_back(k + 4);
        end
        for (int i = 0; i < 8; i++) send(i, i == 0);

        for (int t = 0; t < 40 && (qa0.size() + qb0.size() + q_len.size() != 0 || run_b != 0); t++) idle(1);
        check("queue_a_empty", 64'(qa0.size()), 64'(0));
        check("queue_len_empty", 64'(q_len.size()), 64'(0));
        check("queue_b_empty", 64'(qb0.size()), 64'(0));
        check("abort_count", 64'(n_abort), 64'(1));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
